// File: rtl/wb_regfile.sv
// wb_regfile: x0..x31 integer register file fed by the writeback stage.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    parameter int AW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   rdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [AW-1:0]   rs1D,
    input  logic [AW-1:0]   rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [CNTW-1:0] wr_count,
    output logic [AW-1:0]   last_rd
);

    // x0 is never stored; index 0 is decoded to zero on every port
    logic [XLEN-1:0] r_regs [1:NREGS-1];
    logic [CNTW-1:0] r_wr_count;
    logic [AW-1:0]   r_last_rd;

    logic            w_we;
    logic [AW-1:0]   w_raddr [3];
    logic [XLEN-1:0] w_rdata [3];

    assign w_we = RegWriteW && (rdW != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
            r_last_rd  <= '0;
        end else if (w_we) begin
            r_regs[rdW] <= ResultW;
            r_wr_count  <= r_wr_count + CNTW'(1);
            r_last_rd   <= rdW;
        end
    end

    assign w_raddr[0] = rs1D;
    assign w_raddr[1] = rs2D;
    assign w_raddr[2] = dbg_addr;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rdata[p] = '0;
            if (!reset) begin
                w_rdata[p] = '0;
            end
`ifdef WB_REGFILE_BYPASS_EN
            else if (w_we && (w_raddr[p] == rdW)) begin
                w_rdata[p] = ResultW;
            end
`endif
            else if (w_raddr[p] != '0) begin
                w_rdata[p] = r_regs[w_raddr[p]];
            end
        end
    end

    assign RD1D     = w_rdata[0];
    assign RD2D     = w_rdata[1];
    assign dbg_data = w_rdata[2];
    assign wr_count = r_wr_count;
    assign last_rd  = r_last_rd;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        assert (!((RegWriteW === 1'b1) && $isunknown(rdW)))
        else $error("wb_regfile: RegWriteW=1 with unknown rdW=%b", rdW);
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
// Expectations follow WB_REGFILE_BYPASS_EN for the same-cycle hazard step.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  rdW;
    logic [31:0] ResultW;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] wr_count;
    logic [4:0]  last_rd;

    int checks;
    int failures;

    wb_regfile dut (
        .clk      (clk),
        .reset    (reset),
        .RegWriteW(RegWriteW),
        .rdW      (rdW),
        .ResultW  (ResultW),
        .rs1D     (rs1D),
        .rs2D     (rs2D),
        .RD1D     (RD1D),
        .RD2D     (RD2D),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count),
        .last_rd  (last_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        RegWriteW = 1'b1;
        rdW       = a;
        ResultW   = d;
        @(negedge clk);
        RegWriteW = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        RegWriteW = 1'b0;
        rdW       = '0;
        ResultW   = '0;
        rs1D      = 5'd5;
        rs2D      = 5'd5;
        dbg_addr  = 5'd5;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd1", RD1D, 32'h0);
        chk("rst_cnt", wr_count, 32'h0);
        chk("rst_last", {27'h0, last_rd}, 32'h0);

        @(negedge clk);
        reset = 1'b1;

        wr(5'd5, 32'hA0A0A0A0);
        #1;
        chk("wr5_rd1", RD1D, 32'hA0A0A0A0);
        chk("wr5_dbg", dbg_data, 32'hA0A0A0A0);
        chk("wr5_cnt", wr_count, 32'd1);
        chk("wr5_last", {27'h0, last_rd}, 32'd5);

        @(negedge clk);
        RegWriteW = 1'b1;
        rdW       = 5'd0;
        ResultW   = 32'hFFFFFFFF;
        rs1D      = 5'd0;
        rs2D      = 5'd0;
        dbg_addr  = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("x0_rd1", RD1D, 32'h0);
        chk("x0_rd2", RD2D, 32'h0);
        chk("x0_dbg", dbg_data, 32'h0);
        chk("x0_cnt", wr_count, 32'd1);
        chk("x0_last", {27'h0, last_rd}, 32'd5);
        @(negedge clk);
        RegWriteW = 1'b0;

        wr(5'd7, 32'h00000010);
        RegWriteW = 1'b1;
        rdW       = 5'd7;
        ResultW   = 32'h00000020;
        rs1D      = 5'd7;
        rs2D      = 5'd7;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("haz_pre_rd2", RD2D, 32'h00000020);
        chk("haz_pre_rd1", RD1D, 32'h00000020);
`else
        chk("haz_pre_rd2", RD2D, 32'h00000010);
        chk("haz_pre_rd1", RD1D, 32'h00000010);
`endif
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        chk("haz_post_rd2", RD2D, 32'h00000020);
        chk("haz_post_rd1", RD1D, 32'h00000020);
        chk("haz_cnt", wr_count, 32'd3);
        chk("haz_last", {27'h0, last_rd}, 32'd7);

        wr(5'd9, 32'h00400004);
        @(negedge clk);
        RegWriteW = 1'b0;
        rdW       = 5'd9;
        ResultW   = 32'hC0C0C0C0;
        dbg_addr  = 5'd9;
        @(negedge clk);
        chk("dis_x9", dbg_data, 32'h00400004);
        chk("dis_cnt", wr_count, 32'd4);
        chk("dis_last", {27'h0, last_rd}, 32'd9);

        wr(5'd1, 32'h11111111);
        wr(5'd2, 32'h22222222);
        rs1D = 5'd1;
        rs2D = 5'd2;
        #1;
        chk("mid_pre_x1", RD1D, 32'h11111111);
        chk("mid_pre_cnt", wr_count, 32'd6);
        #3;
        reset     = 1'b0;
        RegWriteW = 1'bx;
        rdW       = 5'd3;
        ResultW   = 32'h33333333;
        #1;
        chk("mid_rst_x1", RD1D, 32'h0);
        chk("mid_rst_x2", RD2D, 32'h0);
        chk("mid_rst_x9", dbg_data, 32'h0);
        chk("mid_rst_cnt", wr_count, 32'h0);
        chk("mid_rst_last", {27'h0, last_rd}, 32'h0);
        @(negedge clk);
        RegWriteW = 1'b1;
        rdW       = 5'd4;
        ResultW   = 32'h44444444;
        @(negedge clk);
        dbg_addr = 5'd4;
        #1;
        chk("mid_hold_x4", dbg_data, 32'h0);
        chk("mid_hold_cnt", wr_count, 32'h0);
        RegWriteW = 1'b0;
        reset     = 1'b1;

        wr(5'd3, 32'hB0B0B0B0);
        #1;
        chk("rel_cnt", wr_count, 32'd1);
        chk("rel_last", {27'h0, last_rd}, 32'd3);
        chk("rel_x1", RD1D, 32'h0);
        chk("rel_x2", RD2D, 32'h0);
        chk("rel_x4", dbg_data, 32'h0);
        dbg_addr = 5'd3;
        #1;
        chk("rel_x3", dbg_data, 32'hB0B0B0B0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
